// File: rtl/ignition_timer_if.sv
// Ignition handshake between the sequencer (master) and ignition_timer (slave).
// CYLINDERS defaults to the `CFG_CYLINDERS build setting, or 4 when that is not set.
`ifndef CFG_CYLINDERS
`define CFG_CYLINDERS 4
`endif

interface ignition_timer_if #(
  parameter int CYLINDERS = `CFG_CYLINDERS,
  parameter int ADV_W     = 6
);
  localparam int CYL_W = (CYLINDERS > 1) ? $clog2(CYLINDERS) : 1;

  logic                 cal_ignition;
  logic [ADV_W-1:0]     advance;
  logic [CYL_W-1:0]     cyl_sel;
  logic                 ignite;
  logic [CYLINDERS-1:0] btdc_ready;
  logic                 err_late;

  modport master (
    output cal_ignition, advance, cyl_sel, ignite,
    input  btdc_ready, err_late
  );

  modport slave (
    input  cal_ignition, advance, cyl_sel, ignite,
    output btdc_ready, err_late
  );
endinterface

// File: rtl/ignition_timer.sv
// Ignition responder: latches advance and cylinder, counts compression ticks, then fires the coil.
// Define HUST_EFI_IGN_LATE_ERR_EN to enable err_late and the debug late counter.
`ifndef CFG_CYLINDERS
`define CFG_CYLINDERS 4
`endif

module ignition_timer #(
  parameter int CYLINDERS    = `CFG_CYLINDERS,
  parameter int TEETH        = 36,
  parameter int ADV_W        = 6,
  parameter int SPARK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 on,
  input  logic [1:0]           stroke,
  input  logic                 crank_tick,
  ignition_timer_if.slave      bus,
  output logic [CYLINDERS-1:0] coil,
  output logic                 busy
);

  localparam int CYL_W = (CYLINDERS > 1) ? $clog2(CYLINDERS) : 1;
  localparam int HALF  = TEETH / 2;
  localparam int SPK_W = (SPARK_CYCLES > 1) ? $clog2(SPARK_CYCLES) : 1;

  localparam logic [ADV_W-1:0] HALF_V   = ADV_W'(HALF);
  localparam logic [SPK_W-1:0] SPK_LAST = SPK_W'(SPARK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, READY, FIRE} state_e;
  typedef enum logic [1:0] {INTAKE, COMPRESSION, COMBUSTION, EXHAUST} stroke_e;

  state_e               state_q, state_d;
  stroke_e              stroke_s;
  logic [ADV_W-1:0]     tick_q;
  logic [ADV_W-1:0]     cnt_next;
  logic [ADV_W-1:0]     target_q;
  logic [ADV_W-1:0]     adv_c;
  logic [CYL_W-1:0]     cyl_q;
  logic [CYL_W-1:0]     cyl_mod;
  logic [SPK_W-1:0]     spark_q;
  logic [CYLINDERS-1:0] cyl_hot;
  logic [CYLINDERS-1:0] btdc_q;
  logic [CYLINDERS-1:0] coil_q;
  logic                 late_evt;
  logic                 latch_req;

  assign stroke_s = stroke_e'(stroke);

  // Saturate the advance to one stroke so the target never wraps below zero.
  assign adv_c   = (bus.advance > HALF_V) ? HALF_V : bus.advance;
  assign cyl_mod = CYL_W'(32'(bus.cyl_sel) % 32'(CYLINDERS));
  assign cyl_hot = CYLINDERS'(1) << cyl_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: every clocked assignment is non-blocking so all registers update from pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: each signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_next  = tick_q;
    late_evt  = 1'b0;
    latch_req = 1'b0;

    if (stroke_s == COMPRESSION && crank_tick && tick_q != '1) begin
      cnt_next = tick_q + ADV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.cal_ignition) begin
          latch_req = 1'b1;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (stroke_s == COMPRESSION && cnt_next >= target_q) begin
          state_d = READY;
        end else if (stroke_s == COMBUSTION) begin
          // Compression was missed entirely; treat it as a late fire.
          late_evt = 1'b1;
          state_d  = IDLE;
        end
      end
      READY: begin
        if (bus.ignite) begin
          state_d = FIRE;
        end else if (stroke_s != COMPRESSION) begin
          late_evt = 1'b1;
          state_d  = IDLE;
        end
      end
      FIRE: begin
        if (spark_q == SPK_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!on) begin
      state_d   = IDLE;
      late_evt  = 1'b0;
      latch_req = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q   <= '0;
      target_q <= '0;
      cyl_q    <= '0;
      spark_q  <= '0;
      btdc_q   <= '0;
      coil_q   <= '0;
    end else begin
      if (latch_req) begin
        target_q <= HALF_V - adv_c;
        cyl_q    <= cyl_mod;
      end
      tick_q  <= (state_q == ARM && state_d == ARM) ? cnt_next : '0;
      spark_q <= (state_q == FIRE && state_d == FIRE) ? spark_q + SPK_W'(1) : '0;
      // Outputs are registered off the next state so they line up with the state register.
      btdc_q  <= (state_d == READY) ? cyl_hot : '0;
      coil_q  <= (state_d == FIRE) ? cyl_hot : '0;
    end
  end

`ifdef HUST_EFI_IGN_LATE_ERR_EN
  logic        err_q;
  logic [15:0] late_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q    <= 1'b0;
      late_cnt <= '0;
    end else begin
      err_q <= late_evt;
      if (late_evt && late_cnt != '1) begin
        late_cnt <= late_cnt + 16'd1;
      end
    end
  end

  assign bus.err_late = err_q;
`else
  logic unused_late;
  assign unused_late  = late_evt;
  assign bus.err_late = 1'b0;
`endif

  assign bus.btdc_ready = btdc_q;
  assign coil           = coil_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ignition_timer.sv
// Directed bench for ignition_timer: table-driven full cycles plus hand-written corner sequences.
module tb_ignition_timer;

  localparam int CYL   = 4;
  localparam int ADV_W = 6;
  localparam int SPARK = 16;

`ifdef HUST_EFI_IGN_LATE_ERR_EN
  localparam logic LATE_ON = 1'b1;
`else
  localparam logic LATE_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           on = 1'b0;
  logic [1:0]     stroke = 2'b11;
  logic           crank_tick = 1'b0;
  logic [CYL-1:0] coil;
  logic           busy;

  ignition_timer_if #(.CYLINDERS(CYL), .ADV_W(ADV_W)) bus ();

  ignition_timer #(
    .CYLINDERS(CYL), .TEETH(36), .ADV_W(ADV_W), .SPARK_CYCLES(SPARK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .on(on), .stroke(stroke),
    .crank_tick(crank_tick), .bus(bus), .coil(coil), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ADV_W-1:0] advance;
    logic [1:0]       cyl;
    int               ticks;
    logic [CYL-1:0]   hot;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [ADV_W-1:0] adv, input logic [1:0] cyl);
    bus.cal_ignition = 1'b1;
    bus.advance      = adv;
    bus.cyl_sel      = cyl;
    stroke           = 2'b11;
    step();
    bus.cal_ignition = 1'b0;
    check("req_busy", busy, 1);
  endtask

  // Intake with a tooth that must not be counted.
  task automatic intake();
    stroke     = 2'b00;
    crank_tick = 1'b1;
    step();
    crank_tick = 1'b0;
    step();
    check("intake_no_ready", bus.btdc_ready, 0);
  endtask

  task automatic compress(input int t, input logic [CYL-1:0] hot);
    stroke = 2'b01;
    if (t == 0) begin
      step();
      check("ready_t0", bus.btdc_ready, hot);
    end else begin
      step();
      check("ready_no_tick", bus.btdc_ready, 0);
      for (int i = 1; i <= t; i++) begin
        crank_tick = 1'b1;
        step();
        crank_tick = 1'b0;
        if (i == t) check("ready_at_target", bus.btdc_ready, hot);
        else if (i == t - 1) check("ready_before_target", bus.btdc_ready, 0);
        if (i < t) step();
      end
    end
  endtask

  task automatic fire_measure(input logic [CYL-1:0] hot);
    int w;
    bus.ignite = 1'b1;
    step();
    bus.ignite = 1'b0;
    check("ready_drop_on_fire", bus.btdc_ready, 0);
    w = 0;
    while (coil === hot && w < 40) begin
      w++;
      step();
    end
    check("coil_width", w, SPARK);
    check("coil_off", coil, 0);
    check("busy_off", busy, 0);
    stroke = 2'b10;
  endtask

  initial begin
    vecs[0] = '{6'd6,  2'd2, 12, 4'b0100};
    vecs[1] = '{6'd0,  2'd0, 18, 4'b0001};
    vecs[2] = '{6'd17, 2'd1, 1,  4'b0010};
    vecs[3] = '{6'd18, 2'd3, 0,  4'b1000};
    vecs[4] = '{6'd63, 2'd2, 0,  4'b0100};
    vecs[5] = '{6'd12, 2'd1, 6,  4'b0010};

    bus.cal_ignition = 1'b0;
    bus.advance      = '0;
    bus.cyl_sel      = '0;
    bus.ignite       = 1'b0;

    #2;
    check("rst_btdc", bus.btdc_ready, 0);
    check("rst_coil", coil, 0);
    check("rst_busy", busy, 0);
    check("rst_err", bus.err_late, 0);
    #20;
    reset_n = 1'b1;
    on      = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // Requests are ignored while disabled.
    on = 1'b0;
    bus.cal_ignition = 1'b1;
    step();
    bus.cal_ignition = 1'b0;
    check("off_ignores_req", busy, 0);
    on = 1'b1;

    for (int v = 0; v < 6; v++) begin
      request(vecs[v].advance, vecs[v].cyl);
      intake();
      compress(vecs[v].ticks, vecs[v].hot);
      fire_measure(vecs[v].hot);
    end

    // Late: ignite withheld, compression ends in READY.
    request(6'd6, 2'd1);
    intake();
    compress(12, 4'b0010);
    stroke = 2'b10;
    step();
    check("late_err", bus.err_late, LATE_ON);
    check("late_btdc", bus.btdc_ready, 0);
    check("late_busy", busy, 0);
    check("late_coil", coil, 0);
    step();
    check("late_err_pulse", bus.err_late, 0);
    check("late_coil_after", coil, 0);

    // Late: compression missed while still in ARM.
    request(6'd0, 2'd3);
    intake();
    stroke = 2'b10;
    step();
    check("arm_late_err", bus.err_late, LATE_ON);
    check("arm_late_busy", busy, 0);
    step();

    // Ignite and stroke change in the same cycle: ignite wins.
    request(6'd6, 2'd2);
    intake();
    compress(12, 4'b0100);
    bus.ignite = 1'b1;
    stroke     = 2'b10;
    step();
    bus.ignite = 1'b0;
    check("race_coil", coil, 4'b0100);
    check("race_err", bus.err_late, 0);
    for (int k = 0; k < 40 && busy === 1'b1; k++) step();
    check("race_done", busy, 0);

    // Drop enable at spark cycle 5.
    request(6'd17, 2'd0);
    intake();
    compress(1, 4'b0001);
    stroke     = 2'b01;
    bus.ignite = 1'b1;
    step();
    bus.ignite = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("spark5_coil", coil, 4'b0001);
    on = 1'b0;
    step();
    check("off_coil", coil, 0);
    check("off_busy", busy, 0);
    on = 1'b1;

    // Second request during ARM must not disturb the latched values.
    request(6'd6, 2'd2);
    bus.cal_ignition = 1'b1;
    bus.advance      = 6'd40;
    bus.cyl_sel      = 2'd0;
    stroke           = 2'b00;
    step();
    bus.cal_ignition = 1'b0;
    check("rereq_busy", busy, 1);
    intake();
    compress(12, 4'b0100);
    fire_measure(4'b0100);

    // Asynchronous reset while READY.
    request(6'd18, 2'd3);
    intake();
    compress(0, 4'b1000);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_btdc", bus.btdc_ready, 0);
    check("areset_busy", busy, 0);
    check("areset_coil", coil, 0);
    check("areset_err", bus.err_late, 0);
    @(negedge clk);
    reset_n = 1'b1;
    stroke  = 2'b11;
    step();
    check("post_reset_idle", busy, 0);
    request(6'd6, 2'd1);
    intake();
    compress(12, 4'b0010);
    fire_measure(4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ignition_timer.md
# ignition_timer

Responder side of the ignition handshake. It answers each one-cycle `cal_ignition` request by latching the spark advance and target cylinder, then counting crank teeth through that cylinder's compression stroke. When the advance point is reached it raises that cylinder's `btdc_ready` bit, accepts the returning `ignite` strobe, and drives a fixed-width spark pulse on the selected coil output. It sits between crank/stroke decode and the coil drivers, opposite the ignition sequencer.

## Interface
Parameters:
- `CYLINDERS`, default `CFG_CYLINDERS` (4): number of cylinders, width of `btdc_ready` and `coil`.
- `TEETH`, default 36: crank ticks per revolution (10°/tick); `HALF = TEETH/2` ticks per stroke.
- `ADV_W`, default 6: width of `advance` and of the internal tick counter; must satisfy 2^ADV_W > HALF.
- `SPARK_CYCLES`, default 16: coil pulse width in clk cycles, ≥1.

Ports (`CYL_W = $clog2(CYLINDERS)`, minimum 1):
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `on`  in  1  enable; low forces IDLE synchronously.
- `cal_ignition`  in  1  one-cycle request, asserted on the exhaust-stroke crank tick.
- `advance`  in  ADV_W  spark advance in ticks before TDC; sampled with `cal_ignition`.
- `cyl_sel`  in  CYL_W  target cylinder; sampled with `cal_ignition`.
- `stroke`  in  2  00 intake, 01 compression, 10 combustion, 11 exhaust.
- `crank_tick`  in  1  one-cycle tooth pulse.
- `ignite`  in  1  fire acknowledge from the sequencer.
- `btdc_ready`  out  CYLINDERS  one-hot, registered: advance point reached.
- `coil`  out  CYLINDERS  one-hot, registered spark pulse.
- `busy`  out  1  high in every state except IDLE.
- `err_late`  out  1  one-cycle pulse: compression ended before `ignite` (see Configuration).

## Operation
- Target computation:
  - `adv_c = min(advance, HALF)` (saturating).
  - `target = HALF - adv_c`.
  - Both are latched in IDLE on `cal_ignition`, together with `cyl_sel`.
  - A `cyl_sel` of `CYLINDERS` or greater is reduced modulo `CYLINDERS`.
- **IDLE**: tick_cnt = 0 and all outputs are 0. When `cal_ignition` and `on` are both high, latch the inputs and go to ARM.
- **ARM**: counts crank ticks during the compression stroke.
  - Each cycle with `stroke==01` and `crank_tick` high increments tick_cnt, saturating at all-ones.
  - Let `cnt_next` be the value after any increment in this cycle. When `stroke==01` and `cnt_next >= target`, go to READY. With `target==0`, this happens on the first cycle of compression, independent of tick arrival.
  - `stroke==10` while in ARM (compression missed) behaves exactly like the late case in READY.
- **READY**: `btdc_ready[cyl]` = 1.
  - `ignite` high: go to FIRE.
  - `ignite` low and `stroke != 01`: late case. Pulse `err_late` and go to IDLE.
  - `ignite` and a stroke change in the same cycle: `ignite` wins.
- **FIRE**: `coil[cyl]` = 1 for exactly SPARK_CYCLES cycles, then IDLE. `btdc_ready` is 0.
- `cal_ignition` outside IDLE is ignored and has no effect on latched values.
- `on` low in any state: next state IDLE, counters cleared, outputs 0 on the next edge. An in-progress spark pulse is truncated.

## Timing
- All outputs are registered. Reset value of every output is 0, state is IDLE, tick_cnt is 0.
- `btdc_ready` rises one cycle after the edge sampling the terminal `crank_tick` (or the first `stroke==01` cycle when `target==0`).
- The sequencer may drive `ignite` combinationally from `btdc_ready`. `ignite` sampled high at edge N gives:
  - `btdc_ready` low from N+1;
  - `coil` high for cycles N+1 .. N+SPARK_CYCLES.
- `err_late` asserts in the cycle after the offending edge, for one cycle.
- Request-to-ARM latency is 1 cycle. `busy` follows the registered state.
- A new `cal_ignition` is accepted on the first IDLE cycle after FIRE/late; there is no back-to-back overlap.

## Configuration
- `HUST_EFI_IGN_LATE_ERR_EN` defined:
  - late detection is active;
  - `err_late` pulses as described;
  - a 16-bit saturating late counter is readable only through simulation hierarchy (debug).
- Not defined:
  - `err_late` is tied to 0 and the counter is removed;
  - the late case still returns to IDLE silently;
  - all other behaviour is identical.

## Test plan
- `advance=6`, `cyl_sel=2`, TEETH=36: `cal_ignition`, then intake, then compression with ticks. After the 12th compression tick, `btdc_ready=4'b0100` next cycle. `ignite` one cycle later gives `coil=4'b0100` for exactly 16 cycles, then `busy=0`.
- `advance=40` (saturates to 18, target 0): `btdc_ready` asserts on the cycle after `stroke` becomes 01, with no tick required.
- Withhold `ignite`; `stroke` 01→10 in READY: `err_late` is a 1-cycle pulse, `btdc_ready` drops, state IDLE, `coil` stays 0. With the macro undefined, `err_late` stays 0.
- `ignite` and `stroke` 01→10 in the same cycle: FIRE is taken, `coil` pulses, `err_late=0`.
- Drop `on` mid-FIRE at spark cycle 5: `coil=0` and `busy=0` next cycle. A second `cal_ignition` during ARM has no effect on the latched `cyl_sel`/`advance`.
- Assert `reset_n` low during READY: all outputs 0 immediately (asynchronous). After release, FSM is in IDLE and awaits `cal_ignition`.
